// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: default widths, FSM states
// and requester port indices.
package dmem_arbiter_pkg;

   localparam int WIDTH_DEF     = 21;
   localparam int ADDR_BITS_DEF = 6;
   localparam int MAX_BURST_DEF = 4;
   localparam int CNT_W         = 4;   // holds MAX_BURST up to 15
   localparam int NUM_PORTS     = 2;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   localparam logic CPU = 1'b0;
   localparam logic EXT = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_grant2.sv
// Two-way round-robin picker: among valid ports allowed by mask, prefer
// port `prio`; returns a one-hot (or zero) grant.
module rr_grant2
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] valid,
   input  logic [1:0] mask,
   input  logic       prio,
   output logic [1:0] grant
);

   logic [1:0] cand;

   assign cand = valid & mask;

   always_comb begin
      grant = cand;
      if (cand == 2'b11)
         grant = (prio == EXT) ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the single-port data memory with capped locked
// bursts; memory controls are combinational, read data is registered.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
)
(
   input  logic                 clk,
   input  logic                 rst,

   input  logic                 m0_req_valid,
   output logic                 m0_req_ready,
   input  logic                 m0_req_we,
   input  logic [ADDR_BITS-1:0] m0_req_addr,
   input  logic [WIDTH-1:0]     m0_req_wdata,
   input  logic                 m0_req_lock,
   output logic                 m0_rsp_valid,
   output logic [WIDTH-1:0]     m0_rsp_rdata,

   input  logic                 m1_req_valid,
   output logic                 m1_req_ready,
   input  logic                 m1_req_we,
   input  logic [ADDR_BITS-1:0] m1_req_addr,
   input  logic [WIDTH-1:0]     m1_req_wdata,
   input  logic                 m1_req_lock,
   output logic                 m1_rsp_valid,
   output logic [WIDTH-1:0]     m1_rsp_rdata,

   output logic [ADDR_BITS-1:0] mem_address,
   output logic [WIDTH-1:0]     mem_datain,
   output logic                 mem_write,
   input  logic [WIDTH-1:0]     mem_dataout
);

   localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);

   logic [NUM_PORTS-1:0]                req_valid, req_we, req_lock;
   logic [NUM_PORTS-1:0][ADDR_BITS-1:0] req_addr;
   logic [NUM_PORTS-1:0][WIDTH-1:0]     req_wdata;

   assign req_valid = {m1_req_valid, m0_req_valid};
   assign req_we    = {m1_req_we,    m0_req_we};
   assign req_lock  = {m1_req_lock,  m0_req_lock};
   assign req_addr  = {m1_req_addr,  m0_req_addr};
   assign req_wdata = {m1_req_wdata, m0_req_wdata};

   arb_state_e        state;
   logic              prio;
   logic              owner;
   logic [CNT_W-1:0]  beat_cnt;

   logic              other;
   logic              owner_v, other_v;
   logic [1:0]        mask;
   logic              eff_prio;
   logic [1:0]        pick, grant;
   logic              gnt_any, gnt_idx;

   assign other   = ~owner;
   assign owner_v = req_valid[owner];
   assign other_v = req_valid[other];

   // In HOLD the owner is forced until the cap is hit with the other side
   // waiting, then the other side is forced for one beat.
   always_comb begin
      mask     = 2'b11;
      eff_prio = prio;
      if (state == HOLD) begin
         if (owner_v) begin
            if ((beat_cnt < BURST_CAP) || !other_v)
               mask = owner ? 2'b10 : 2'b01;
            else
               mask = owner ? 2'b01 : 2'b10;
         end else begin
            eff_prio = other;
         end
      end
   end

   rr_grant2 u_pick (
      .valid (req_valid),
      .mask  (mask),
      .prio  (eff_prio),
      .grant (pick)
   );

   // Reset kills the grant so nothing reaches the memory while it is held.
   assign grant   = rst ? 2'b00 : pick;
   assign gnt_any = |grant;
   assign gnt_idx = grant[1];

   assign m0_req_ready = grant[0];
   assign m1_req_ready = grant[1];

   assign mem_address = gnt_any ? req_addr[gnt_idx]  : '0;
   assign mem_datain  = gnt_any ? req_wdata[gnt_idx] : '0;
   assign mem_write   = gnt_any & req_we[gnt_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ARB;
         prio     <= CPU;
         owner    <= CPU;
         beat_cnt <= '0;
      end else if (state == HOLD && gnt_any && gnt_idx == owner) begin
         if (beat_cnt != BURST_CAP)
            beat_cnt <= beat_cnt + CNT_W'(1);
         if (!req_lock[owner]) begin
            state <= ARB;
            prio  <= other;
         end
      end else if (gnt_any) begin
         // Plain arbitration, a capped hand-over, or owner dropped valid.
         prio <= ~gnt_idx;
         if (req_lock[gnt_idx]) begin
            state    <= HOLD;
            owner    <= gnt_idx;
            beat_cnt <= CNT_W'(1);
         end else begin
            state <= ARB;
         end
      end else if (state == HOLD) begin
         state <= ARB;
         prio  <= other;
      end
   end

   logic [NUM_PORTS-1:0]            rsp_valid;
   logic [NUM_PORTS-1:0][WIDTH-1:0] rsp_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_valid[p] <= grant[p] & ~req_we[p];
            if (grant[p] && !req_we[p])
               rsp_rdata[p] <= mem_dataout;
         end
      end
   end

   assign m0_rsp_valid = rsp_valid[0];
   assign m1_rsp_valid = rsp_valid[1];
   assign m0_rsp_rdata = rsp_rdata[0];
   assign m1_rsp_rdata = rsp_rdata[1];

endmodule
